// File: rtl/dmem_mmio_bridge.sv
// ----------------------------------------------------------------------------
// dmem_mmio_bridge
// Sits on the processor data-memory port. Each word access is routed to the
// synchronous data RAM, to a small MMIO register block (LED, timer, UART TX
// FIFO), or to unmapped space. Loads have one cycle of latency.
//
// Ports:
//   clock, reset          master clock, asynchronous active-low reset
//   address_dmem, data,   processor word address, store data, store enable
//   wren
//   q_dmem                load data (valid one cycle after the address)
//   ram_address/data/wren request to the external synchronous RAM
//   ram_q                 RAM read data (one cycle after ram_address)
//   led                   LED register
//   tx_data, tx_valid,    UART TX FIFO head and valid/ready drain handshake
//   tx_ready
//   irq_timer             timer interrupt (match & irq_en)
// ----------------------------------------------------------------------------
module dmem_mmio_bridge #(
    parameter int          RAM_AWIDTH = 12,
    parameter logic [31:0] MMIO_BASE  = 32'h0000_F000,
    parameter int          TX_DEPTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           address_dmem,
    input  logic [31:0]           data,
    input  logic                  wren,
    output logic [31:0]           q_dmem,
    output logic [RAM_AWIDTH-1:0] ram_address,
    output logic [31:0]           ram_data,
    output logic                  ram_wren,
    input  logic [31:0]           ram_q,
    output logic [15:0]           led,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  irq_timer
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(TX_DEPTH);

    localparam logic [3:0] OFF_LED   = 4'd0;
    localparam logic [3:0] OFF_CNT   = 4'd1;
    localparam logic [3:0] OFF_CMP   = 4'd2;
    localparam logic [3:0] OFF_CTRL  = 4'd3;
    localparam logic [3:0] OFF_STAT  = 4'd4;
    localparam logic [3:0] OFF_TX    = 4'd5;
    localparam logic [3:0] OFF_USTAT = 4'd6;

    // Registers
    logic [15:0]      r_led;
    logic [31:0]      r_cnt;
    logic [31:0]      r_cmp;
    logic [2:0]       r_ctrl;
    logic             r_match;
    logic [7:0]       r_fifo [TX_DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf;
    logic             r_rd_ram;
    logic [31:0]      r_rd_reg;

    // Wires
    logic        w_sel_ram;
    logic        w_sel_mmio;
    logic [3:0]  w_off;
    logic        w_wr_mmio;
    logic        w_match_now;
    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push_ok;
    logic [3:0]  w_cnt4;
    logic [31:0] w_rd_mmio;

    assign w_sel_ram   = (address_dmem[31:RAM_AWIDTH] == {(32-RAM_AWIDTH){1'b0}});
    assign w_sel_mmio  = (address_dmem[31:4] == MMIO_BASE[31:4]);
    assign w_off       = address_dmem[3:0];
    assign w_wr_mmio   = wren & w_sel_mmio;

    assign ram_address = address_dmem[RAM_AWIDTH-1:0];
    assign ram_data    = data;
    assign ram_wren    = wren & w_sel_ram;

    assign w_match_now = r_ctrl[0] && (r_cnt == r_cmp);

    assign w_empty     = (r_count == {CNT_W{1'b0}});
    assign w_full      = (r_count == CNT_FULL);
    assign w_pop       = ~w_empty & tx_ready;
    assign w_push_req  = w_wr_mmio && (w_off == OFF_TX);
    // A push into a full FIFO still fits when the head leaves in the same cycle.
    assign w_push_ok   = w_push_req && (!w_full || w_pop);
    assign w_cnt4      = 4'(r_count);

    assign led         = r_led;
    assign tx_valid    = ~w_empty;
    assign tx_data     = w_empty ? 8'h00 : r_fifo[r_head];
    assign irq_timer   = r_match & r_ctrl[1];
    assign q_dmem      = r_rd_ram ? ram_q : r_rd_reg;

    // MMIO read mux, built from pre-write register state
    always_comb begin
        w_rd_mmio = 32'h0000_0000;
        case (w_off)
            OFF_LED:   w_rd_mmio = {16'h0000, r_led};
            OFF_CNT:   w_rd_mmio = r_cnt;
            OFF_CMP:   w_rd_mmio = r_cmp;
            OFF_CTRL:  w_rd_mmio = {29'h0000_0000, r_ctrl};
            OFF_STAT:  w_rd_mmio = {31'h0000_0000, r_match};
            OFF_USTAT: w_rd_mmio = {24'h00_0000, w_cnt4, 1'b0, r_ovf, w_full, w_empty};
            default:   w_rd_mmio = 32'h0000_0000;
        endcase
    end

    // Load pipeline: remember the target and the register value for next cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ram <= 1'b0;
            r_rd_reg <= 32'h0000_0000;
        end else begin
            r_rd_ram <= w_sel_ram;
            r_rd_reg <= w_sel_mmio ? w_rd_mmio : 32'h0000_0000;
        end
    end

    // LED, compare and control registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_led  <= 16'h0000;
            r_cmp  <= 32'h0000_0000;
            r_ctrl <= 3'b000;
        end else begin
            if (w_wr_mmio && (w_off == OFF_LED))  r_led  <= data[15:0];
            if (w_wr_mmio && (w_off == OFF_CMP))  r_cmp  <= data;
            if (w_wr_mmio && (w_off == OFF_CTRL)) r_ctrl <= data[2:0];
        end
    end

    // Timer counter and sticky match flag; a match set beats a W1C clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt   <= 32'h0000_0000;
            r_match <= 1'b0;
        end else begin
            if (w_wr_mmio && (w_off == OFF_CNT)) begin
                r_cnt <= data;
            end else if (r_ctrl[0]) begin
                r_cnt <= (w_match_now && r_ctrl[2]) ? 32'h0000_0000 : r_cnt + 32'h0000_0001;
            end
            if (w_match_now) begin
                r_match <= 1'b1;
            end else if (w_wr_mmio && (w_off == OFF_STAT) && data[0]) begin
                r_match <= 1'b0;
            end
        end
    end

    // UART TX FIFO storage, pointers, occupancy and sticky overflow
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < TX_DEPTH; i++) begin
                r_fifo[i] <= 8'h00;
            end
            r_head  <= {PTR_W{1'b0}};
            r_tail  <= {PTR_W{1'b0}};
            r_count <= {CNT_W{1'b0}};
            r_ovf   <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_tail] <= data[7:0];
                r_tail         <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
            if (w_push_req && !w_push_ok) begin
                r_ovf <= 1'b1;
            end else if (w_wr_mmio && (w_off == OFF_USTAT)) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_mmio_bridge.sv
module tb_dmem_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic [11:0] ram_address;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [15:0] led;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq_timer;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [31:0] MMIO = 32'h0000_F000;

    dmem_mmio_bridge #(.RAM_AWIDTH(12), .MMIO_BASE(32'h0000_F000), .TX_DEPTH(8)) dut (
        .clock(clock), .reset(reset), .address_dmem(address_dmem), .data(data), .wren(wren),
        .q_dmem(q_dmem), .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q), .led(led), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .irq_timer(irq_timer)
    );

    always #5 clock = ~clock;

    // External synchronous RAM driven by the DUT
    logic [31:0] tb_mem [4096];
    always @(posedge clock) begin
        if (ram_wren) tb_mem[ram_address] <= ram_data;
        ram_q <= tb_mem[ram_address];
    end

    // Reference model state
    logic [31:0] m_ram [4096];
    logic [15:0] m_led;
    logic [31:0] m_cnt, m_cmp, m_q;
    logic [2:0]  m_ctrl;
    logic        m_match, m_ovf;
    logic [7:0]  m_fifo [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_led = 16'h0; m_cnt = 32'h0; m_cmp = 32'h0; m_ctrl = 3'b0;
        m_match = 1'b0; m_ovf = 1'b0; m_q = 32'h0;
        m_fifo.delete();
    endtask

    // One bus cycle: drive, check request side, clock, advance model, check outputs
    task automatic do_cycle(input logic [31:0] a, input logic [31:0] d, input logic we, input logic rdy);
        logic        is_ram, is_mmio, pop, hit, accept;
        logic [3:0]  off;
        logic [31:0] rv;
        int          sz;
        address_dmem = a; data = d; wren = we; tx_ready = rdy;
        #1;
        is_ram  = (a < 32'd4096);
        is_mmio = (a >= MMIO) && (a < MMIO + 32'd16);
        off     = a[3:0];
        chk("ram_wren", {31'b0, ram_wren}, {31'b0, is_ram & we});
        chk("ram_address", {20'b0, ram_address}, {20'b0, a[11:0]});
        @(posedge clock);
        #1;
        sz = m_fifo.size();
        rv = 32'h0;
        if (is_ram) rv = m_ram[a[11:0]];
        else if (is_mmio) begin
            case (off)
                4'd0: rv = {16'h0, m_led};
                4'd1: rv = m_cnt;
                4'd2: rv = m_cmp;
                4'd3: rv = {29'h0, m_ctrl};
                4'd4: rv = {31'h0, m_match};
                4'd6: rv = (sz == 0 ? 1 : 0) + (sz == 8 ? 2 : 0) + (m_ovf ? 4 : 0) + sz * 16;
                default: rv = 32'h0;
            endcase
        end
        m_q = rv;
        hit = m_ctrl[0] && (m_cnt == m_cmp);
        if (is_mmio && we && off == 4'd1) m_cnt = d;
        else if (m_ctrl[0]) m_cnt = (hit && m_ctrl[2]) ? 32'h0 : m_cnt + 32'd1;
        if (hit) m_match = 1'b1;
        else if (is_mmio && we && off == 4'd4 && d[0]) m_match = 1'b0;
        pop = (sz > 0) && rdy;
        if (pop) void'(m_fifo.pop_front());
        if (is_mmio && we && off == 4'd5) begin
            accept = (sz < 8) || pop;
            if (accept) m_fifo.push_back(d[7:0]);
            else m_ovf = 1'b1;
        end
        if (is_mmio && we && off == 4'd6) m_ovf = 1'b0;
        if (is_mmio && we && off == 4'd0) m_led = d[15:0];
        if (is_mmio && we && off == 4'd2) m_cmp = d;
        if (is_mmio && we && off == 4'd3) m_ctrl = d[2:0];
        if (is_ram && we) m_ram[a[11:0]] = d;
        chk("q_dmem", q_dmem, m_q);
        chk("led", {16'h0, led}, {16'h0, m_led});
        chk("tx_valid", {31'b0, tx_valid}, {31'b0, m_fifo.size() > 0});
        chk("tx_data", {24'h0, tx_data}, {24'h0, (m_fifo.size() > 0) ? m_fifo[0] : 8'h00});
        chk("irq_timer", {31'b0, irq_timer}, {31'b0, m_match & m_ctrl[1]});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] ra, rd;
        int kind;
        for (int i = 0; i < 4096; i++) begin
            tb_mem[i] = 32'h0;
            m_ram[i]  = 32'h0;
        end
        ram_q = 32'h0;
        reset = 1'b0; address_dmem = 32'h0; data = 32'h0; wren = 1'b0; tx_ready = 1'b0;
        model_reset();
        #12;
        reset = 1'b1;
        chk("rst_q", q_dmem, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_txv", {31'b0, tx_valid}, 32'h0);
        chk("rst_irq", {31'b0, irq_timer}, 32'h0);

        // RAM path
        do_cycle(32'h10, 32'hDEAD_BEEF, 1'b1, 1'b0);
        do_cycle(32'h10, 32'h0, 1'b0, 1'b0);
        chk("ram_read", q_dmem, 32'hDEAD_BEEF);

        // LED and unmapped space
        do_cycle(MMIO, 32'h1234_ABCD, 1'b1, 1'b0);
        chk("led_val", {16'h0, led}, 32'h0000_ABCD);
        do_cycle(MMIO, 32'h0, 1'b0, 1'b0);
        chk("led_rd", q_dmem, 32'h0000_ABCD);
        do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        chk("unmap_rd", q_dmem, 32'h0);
        do_cycle(32'h0010_0000, 32'h5555_5555, 1'b1, 1'b0);
        chk("unmap_wr_led", {16'h0, led}, 32'h0000_ABCD);

        // Timer: compare 5, enable + irq + clear-on-match
        do_cycle(MMIO + 32'd2, 32'd5, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd3, 32'd7, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd1, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        chk("irq_before", {31'b0, irq_timer}, 32'h0);
        do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        chk("irq_match", {31'b0, irq_timer}, 32'h1);
        do_cycle(MMIO + 32'd1, 32'h0, 1'b0, 1'b0);
        chk("cnt_cleared", q_dmem, 32'h0);
        do_cycle(MMIO + 32'd4, 32'h1, 1'b1, 1'b0);
        chk("w1c_clear", {31'b0, irq_timer}, 32'h0);
        for (int i = 0; i < 3; i++) do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        do_cycle(MMIO + 32'd4, 32'h1, 1'b1, 1'b0);
        chk("set_wins", {31'b0, irq_timer}, 32'h1);
        do_cycle(MMIO + 32'd3, 32'd0, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd4, 32'h1, 1'b1, 1'b0);

        // FIFO fill with overflow
        for (int i = 0; i < 9; i++) do_cycle(MMIO + 32'd5, 32'h41 + i, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd6, 32'h0, 1'b0, 1'b0);
        chk("stat_full", q_dmem, 32'h0000_0086);
        chk("head_41", {24'h0, tx_data}, 32'h41);

        // Drain
        for (int i = 0; i < 8; i++) begin
            chk("drain_seq", {24'h0, tx_data}, 32'h41 + i);
            do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b1);
        end
        chk("drained_valid", {31'b0, tx_valid}, 32'h0);
        chk("drained_data", {24'h0, tx_data}, 32'h0);
        do_cycle(MMIO + 32'd6, 32'h0, 1'b0, 1'b1);
        chk("stat_empty", q_dmem, 32'h0000_0005);
        do_cycle(MMIO + 32'd6, 32'h0, 1'b1, 1'b0);

        // Push while full with a simultaneous pop
        for (int i = 0; i < 8; i++) do_cycle(MMIO + 32'd5, 32'h41 + i, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd5, 32'h50, 1'b1, 1'b1);
        do_cycle(MMIO + 32'd6, 32'h0, 1'b0, 1'b0);
        chk("full_pushpop", q_dmem, 32'h0000_0082);
        chk("head_42", {24'h0, tx_data}, 32'h42);
        for (int i = 0; i < 5; i++) do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b1);

        // Async reset with 3 bytes queued and irq pending
        do_cycle(MMIO + 32'd1, 32'd0, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd2, 32'd2, 1'b1, 1'b0);
        do_cycle(MMIO + 32'd3, 32'd3, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) do_cycle(32'h0010_0000, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_irq", {31'b0, irq_timer}, 32'h1);
        do_cycle(MMIO, 32'h5555, 1'b1, 1'b0);
        do_cycle(MMIO, 32'h0, 1'b0, 1'b0);
        chk("pre_rst_q", q_dmem, 32'h5555);
        chk("pre_rst_txv", {31'b0, tx_valid}, 32'h1);
        #3;
        reset = 1'b0;
        #1;
        chk("arst_q", q_dmem, 32'h0);
        chk("arst_led", {16'h0, led}, 32'h0);
        chk("arst_txv", {31'b0, tx_valid}, 32'h0);
        chk("arst_irq", {31'b0, irq_timer}, 32'h0);
        model_reset();
        #3;
        reset = 1'b1;

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            kind = int'($urandom_range(0, 5));
            rd   = $urandom;
            if (kind == 0) ra = $urandom_range(0, 31);
            else if (kind <= 3) begin
                ra = MMIO + $urandom_range(0, 15);
                if (ra[3:0] == 4'd1 || ra[3:0] == 4'd2) rd = $urandom_range(0, 30);
            end else if (kind == 4) ra = MMIO + 32'd16 + $urandom_range(0, 3);
            else ra = 32'd4096 + $urandom_range(0, 3);
            do_cycle(ra, rd, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_bridge.md
Name: dmem_mmio_bridge

Overview:
Sits directly downstream of the processor's data-memory port: takes address_dmem/data/wren and returns q_dmem.
- Decodes each access to one of three targets: the synchronous data RAM, a small MMIO register file, or unmapped space.
- MMIO space holds an LED register, a 32-bit timer with compare/interrupt, and an 8-entry UART transmit FIFO with a valid/ready drain port.

Parameters:
RAM_AWIDTH, 12, RAM word-address width; RAM region is address_dmem[31:RAM_AWIDTH]==0.
MMIO_BASE, 32'h0000_F000, word address of MMIO offset 0; MMIO region is MMIO_BASE..MMIO_BASE+15.
TX_DEPTH, 8, UART FIFO entries (power of 2).

Ports:
clock  in  1  master clock, all state updates on rising edge
reset  in  1  asynchronous, active-low reset
address_dmem  in  32  word address from processor
data  in  32  store data from processor
wren  in  1  store enable from processor
q_dmem  out  32  load data to processor
ram_address  out  RAM_AWIDTH  to data RAM
ram_data  out  32  to data RAM
ram_wren  out  1  to data RAM
ram_q  in  32  from data RAM (valid one cycle after address)
led  out  16  LED register [15:0]
tx_data  out  8  FIFO head byte
tx_valid  out  1  FIFO non-empty
tx_ready  in  1  UART consumer accepts head this cycle
irq_timer  out  1  timer interrupt

Behaviour:
Reset (reset==0, async):
- All registers, FIFO pointers/count, timer, and sticky flags go to 0.
- Resulting outputs: q_dmem=0, led=0, tx_valid=0, irq_timer=0.
- Reset mid-transfer discards FIFO contents and any in-flight read.

Decode (combinational):
- sel_ram = address_dmem[31:RAM_AWIDTH]==0.
- sel_mmio = address_dmem[31:4]==MMIO_BASE[31:4].
- Otherwise unmapped.
- ram_address=address_dmem[RAM_AWIDTH-1:0]; ram_data=data; ram_wren=wren&sel_ram.

Reads:
- 1-cycle latency. At the rising edge, register sel_ram into rd_ram and the selected MMIO/zero value into rd_reg.
- q_dmem = rd_ram ? ram_q : rd_reg.
- Unmapped reads and unlisted MMIO offsets return 0. Unmapped writes are ignored.

MMIO map (offset = address_dmem[3:0]):
- 0 LED: RW, bits[15:0]; reads zero-extended.
- 1 TIMER_CNT: RW. A write loads the count.
- 2 TIMER_CMP: RW.
- 3 TIMER_CTRL: RW bits[2:0]. bit0 en, bit1 irq_en, bit2 clr_on_match.
- 4 TIMER_STAT: bit0 match, sticky. Writing 1 to bit0 clears it.
- 5 UART_TX: write-only, pushes data[7:0]. Reads return 0.
- 6 UART_STAT: read-only. bit0 empty, bit1 full, bit2 overflow (sticky), bits[7:4] count. Writing any value clears overflow.

Timer:
- When en is set, cnt increments every cycle and wraps 32'hFFFF_FFFF -> 0.
- Match condition: en && cnt==cmp. On match, match<=1. If clr_on_match is set, cnt<=0 next cycle instead of incrementing.
- A software write to TIMER_CNT takes priority over increment/clear.
- If a match set and a W1C clear occur in the same cycle, set wins.
- irq_timer = match & irq_en, taken from registered state (no combinational path from the bus).

UART FIFO:
- Circular buffer of TX_DEPTH entries; count ranges 0..TX_DEPTH.
- Pop = tx_valid & tx_ready; head advances.
- Push = a write to offset 5. It is accepted if count<TX_DEPTH, or if count==TX_DEPTH and a pop occurs in the same cycle.
- A rejected push drops the byte and sets overflow.
- Simultaneous push+pop leaves count unchanged.
- tx_data = head entry; it is undefined-free: 0 when empty.
- Pointers wrap modulo TX_DEPTH.

Read-after-write to the same MMIO register in consecutive cycles returns the new value. Read and write in the same cycle return the pre-write value.

Test Plan:
- Reset: assert reset=0 mid-run with FIFO holding 3 bytes -> q_dmem=0, tx_valid=0, led=0, irq_timer=0 immediately, without waiting for a clock edge.
- RAM path: write 0xDEADBEEF to address 0x10 -> ram_wren=1, ram_address=0x10. Then read 0x10 with the model RAM returning 0xDEADBEEF -> q_dmem=0xDEADBEEF one cycle later.
- LED/unmapped: write 0x1234_ABCD to MMIO+0 -> led=0xABCD, readback 0x0000ABCD. Read 0x0010_0000 -> 0. Write 0x0010_0000 -> ram_wren=0, led unchanged.
- Timer: CMP=5, CTRL=0b111, CNT=0 -> match=1 and irq_timer=1 on the cycle after cnt reaches 5; cnt returns to 0. W1C on STAT clears match; a write colliding with the next match leaves match=1.
- FIFO full/overflow: with tx_ready=0, push 9 bytes 0x41..0x49 -> STAT=full, count=8, overflow=1, tx_data=0x41. Push with tx_ready=1 while full -> accepted, count stays 8.
- Drain: tx_ready=1 for 8 cycles -> tx_data sequence 0x41..0x48, then tx_valid=0 and STAT empty=1.
